// File: rtl/puf_seq_pkg.sv
// Shared types and constants for the PUF challenge sequencer.
// Holds FSM state encoding, default phase lengths and timer sizing.
package puf_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLR,
    S_RUN,
    S_SETTLE,
    S_SAMPLE,
    S_DONE
  } state_e;

  localparam int DEF_CLR_CYC    = 4;
  localparam int DEF_WINDOW     = 4095;
  localparam int DEF_SETTLE_CYC = 8;

  // Width needed to hold (longest phase - 1), at least 1 bit.
  function automatic int tmr_width(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/puf_phase_timer.sv
// Loadable down-counter shared by the CLR, RUN and SETTLE phases.
// Ports: clk_i, rst_i, load_i, load_val_i (len-1), tc_o (count at zero).
module puf_phase_timer #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Terminal count marks the last cycle of the current phase.
  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/puf_challenge_seq.sv
// Sequences RO-pair measurements on the 16-RO PUF core and builds a response.
// Ports: clock/reset, start/abort/challenge, select1/2, ro_enable/ro_reset,
// puf_in, busy, resp_valid/resp_ready/response. Macro PUF_MAJORITY_EN
// enables a 3-pass majority vote per response bit.
module puf_challenge_seq
  import puf_seq_pkg::*;
#(
  parameter int N_SEL_W    = 4,
  parameter int RESP_BITS  = 8,
  parameter int CLR_CYC    = DEF_CLR_CYC,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [N_SEL_W-1:0]   challenge,
  output logic [N_SEL_W-1:0]   select1,
  output logic [N_SEL_W-1:0]   select2,
  output logic                 ro_enable,
  output logic                 ro_reset,
  input  logic                 puf_in,
  output logic                 busy,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [RESP_BITS-1:0] response
);

  localparam int TW = tmr_width(CLR_CYC, WINDOW, SETTLE_CYC);
  localparam int BW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;

  localparam logic [TW-1:0] LD_CLR = TW'(CLR_CYC - 1);
  localparam logic [TW-1:0] LD_RUN = TW'(WINDOW - 1);
  localparam logic [TW-1:0] LD_SET = TW'(SETTLE_CYC - 1);
  localparam logic [BW-1:0] LAST   = BW'(RESP_BITS - 1);

  state_e state_q, state_d;

  logic [N_SEL_W-1:0]   base_q, base_d;
  logic [BW-1:0]        bit_idx_q, bit_idx_d;
  logic [RESP_BITS-1:0] resp_q, resp_d;
  logic [N_SEL_W-1:0]   sel1_q, sel1_d;
  logic [N_SEL_W-1:0]   sel2_q, sel2_d;
  logic                 en_q, en_d;
  logic                 rst_q, rst_d;
  logic                 busy_q, busy_d;
  logic                 valid_q, valid_d;

`ifdef PUF_MAJORITY_EN
  logic [1:0] pass_q, pass_d;
  logic [1:0] vote_q, vote_d;
  logic [1:0] vsum;
`endif

  logic          adv;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tc;

  // Timer restarts whenever a new phase is entered.
  always_comb begin
    tmr_load = (state_d != state_q);
    tmr_val  = '0;
    unique case (state_d)
      S_CLR:    tmr_val = LD_CLR;
      S_RUN:    tmr_val = LD_RUN;
      S_SETTLE: tmr_val = LD_SET;
      default:  tmr_val = '0;
    endcase
  end

  puf_phase_timer #(
    .W (TW)
  ) u_timer (
    .clk_i      (clock),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .tc_o       (tc)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      base_q    <= '0;
      bit_idx_q <= '0;
      resp_q    <= '0;
      sel1_q    <= '0;
      sel2_q    <= '0;
      en_q      <= 1'b0;
      rst_q     <= 1'b1;
      busy_q    <= 1'b0;
      valid_q   <= 1'b0;
`ifdef PUF_MAJORITY_EN
      pass_q    <= '0;
      vote_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      bit_idx_q <= bit_idx_d;
      resp_q    <= resp_d;
      sel1_q    <= sel1_d;
      sel2_q    <= sel2_d;
      en_q      <= en_d;
      rst_q     <= rst_d;
      busy_q    <= busy_d;
      valid_q   <= valid_d;
`ifdef PUF_MAJORITY_EN
      pass_q    <= pass_d;
      vote_q    <= vote_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    bit_idx_d = bit_idx_q;
    resp_d    = resp_q;
    adv       = 1'b0;
`ifdef PUF_MAJORITY_EN
    pass_d    = pass_q;
    vote_d    = vote_q;
    vsum      = vote_q + {1'b0, puf_in};
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_CLR;
          base_d    = challenge;
          resp_d    = '0;
          bit_idx_d = '0;
        end
      end
      S_CLR: begin
        if (tc) state_d = S_RUN;
      end
      S_RUN: begin
        if (tc) state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (tc) state_d = S_SAMPLE;
      end
      S_SAMPLE: begin
`ifdef PUF_MAJORITY_EN
        // Vote sum reaches 2 or 3 exactly when its MSB is set.
        if (pass_q == 2'd2) begin
          resp_d[bit_idx_q] = vsum[1];
          pass_d = '0;
          vote_d = '0;
          adv    = 1'b1;
        end else begin
          pass_d  = pass_q + 2'd1;
          vote_d  = vsum;
          state_d = S_CLR;
        end
`else
        resp_d[bit_idx_q] = puf_in;
        adv = 1'b1;
`endif
        if (adv) begin
          if (bit_idx_q == LAST) begin
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + BW'(1);
            state_d   = S_CLR;
          end
        end
      end
      S_DONE: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      resp_d    = '0;
      bit_idx_d = '0;
`ifdef PUF_MAJORITY_EN
      pass_d    = '0;
      vote_d    = '0;
`endif
    end
  end

  // Outputs are derived from the next state so they register in step with it.
  always_comb begin
    sel1_d  = sel1_q;
    sel2_d  = sel2_q;
    en_d    = (state_d == S_RUN);
    rst_d   = (state_d == S_IDLE) || (state_d == S_CLR) ||
              (state_d == S_DONE);
    busy_d  = (state_d != S_IDLE);
    valid_d = (state_d == S_DONE);
    if ((state_d == S_CLR) && (state_q != S_CLR)) begin
      sel1_d = base_d + N_SEL_W'({bit_idx_d, 1'b0});
      sel2_d = sel1_d + N_SEL_W'(1);
    end
  end

  assign select1    = sel1_q;
  assign select2    = sel2_q;
  assign ro_enable  = en_q;
  assign ro_reset   = rst_q;
  assign busy       = busy_q;
  assign resp_valid = valid_q;
  assign response   = resp_q;

endmodule

// File: tb/tb_puf_challenge_seq.sv
// Directed bench for puf_challenge_seq with shortened phase lengths.
// Table of challenges/patterns plus abort, reset and handshake sequences.
module tb_puf_challenge_seq;

  localparam int CLR = 2;
  localparam int WIN = 10;
  localparam int SET = 3;
  localparam int NB  = 8;
  localparam int PER = CLR + WIN + SET + 1;
`ifdef PUF_MAJORITY_EN
  localparam int PASSES = 3;
`else
  localparam int PASSES = 1;
`endif
  localparam int BITP = PER * PASSES;
  localparam int TOT  = BITP * NB;

  logic       clock;
  logic       reset;
  logic       start;
  logic       abort;
  logic [3:0] challenge;
  logic [3:0] select1;
  logic [3:0] select2;
  logic       ro_enable;
  logic       ro_reset;
  logic       puf_in;
  logic       busy;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] response;

  int total = 0;
  int bad   = 0;

  puf_challenge_seq #(
    .N_SEL_W    (4),
    .RESP_BITS  (NB),
    .CLR_CYC    (CLR),
    .WINDOW     (WIN),
    .SETTLE_CYC (SET)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .challenge  (challenge),
    .select1    (select1),
    .select2    (select2),
    .ro_enable  (ro_enable),
    .ro_reset   (ro_reset),
    .puf_in     (puf_in),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .response   (response)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [3:0] ch;
    logic [7:0] pat;
    logic [7:0] exp;
    logic [3:0] s1a;
    logic [3:0] s2a;
    logic [3:0] s1b;
    logic [3:0] s2b;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(
    input string       nm,
    input logic [31:0] a,
    input logic [31:0] e
  );
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  // Majority build: passes drive bit,0,1 so the vote equals the bit.
  function automatic logic puf_val(
    input logic [7:0] pat,
    input int         b,
    input int         p
  );
    if (p == 1) return 1'b0;
    if (p == 2) return 1'b1;
    return pat[b];
  endfunction

  task automatic run_one(input vec_t v);
    logic [11:0] act;
    logic [11:0] expv;
    logic [3:0]  e1;
    @(negedge clock);
    challenge = v.ch;
    start     = 1'b1;
    puf_in    = 1'b0;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < TOT; k++) begin
      int o;
      int p;
      int b;
      o      = k % PER;
      p      = (k / PER) % PASSES;
      b      = k / BITP;
      puf_in = puf_val(v.pat, b, p);
      e1     = v.ch + 4'(2 * b);
      act    = {resp_valid, busy, ro_enable, ro_reset,
                select1, select2};
      expv   = {1'b0, 1'b1, (o >= CLR) && (o < CLR + WIN),
                (o < CLR), e1, e1 + 4'd1};
      chk("phase", 32'(act), 32'(expv));
      if (k == 0)
        chk("pair0", {select1, select2}, {v.s1a, v.s2a});
      if (k == BITP)
        chk("pair1", {select1, select2}, {v.s1b, v.s2b});
      @(posedge clock);
      #1;
    end
    chk("valid_rise", {resp_valid, busy}, 2'b11);
    chk("response", response, v.exp);
  endtask

  task automatic hold_and_ack(input logic [7:0] e);
    for (int i = 0; i < 20; i++) begin
      chk("hold", {resp_valid, busy, response}, {2'b11, e});
      start     = (i == 5);
      challenge = 4'h9;
      @(posedge clock);
      #1;
    end
    start      = 1'b1;
    resp_ready = 1'b1;
    @(posedge clock);
    #1;
    start      = 1'b0;
    resp_ready = 1'b0;
    chk("ack", {resp_valid, busy, ro_reset, ro_enable}, 4'b0010);
    @(posedge clock);
    #1;
    chk("idle_stay", {busy, response}, {1'b0, e});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t va;
    reset      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    challenge  = 4'h0;
    puf_in     = 1'b0;
    resp_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_state",
        {select1, select2, ro_enable, ro_reset, busy,
         resp_valid, response},
        {4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});
    @(negedge clock);
    reset = 1'b0;

    vecs[0] = '{4'h0, 8'hFF, 8'hFF, 4'h0, 4'h1, 4'h2, 4'h3};
    vecs[1] = '{4'hF, 8'h4D, 8'b01001101, 4'hF, 4'h0, 4'h1, 4'h2};
    vecs[2] = '{4'h5, 8'h00, 8'h00, 4'h5, 4'h6, 4'h7, 4'h8};
    vecs[3] = '{4'hA, 8'hA5, 8'hA5, 4'hA, 4'hB, 4'hC, 4'hD};

    for (int i = 0; i < 4; i++) begin
      run_one(vecs[i]);
      hold_and_ack(vecs[i].exp);
    end

    // Abort during RUN of bit 3.
    @(negedge clock);
    challenge = 4'h3;
    start     = 1'b1;
    puf_in    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < 3 * BITP + CLR + 3; k++) begin
      @(posedge clock);
      #1;
    end
    chk("pre_abort", {ro_enable, busy, response},
        {2'b11, 8'h07});
    abort = 1'b1;
    @(posedge clock);
    #1;
    abort = 1'b0;
    chk("abort",
        {ro_enable, ro_reset, resp_valid, busy, response},
        {4'b0100, 8'h00});
    va = vecs[1];
    run_one(va);
    hold_and_ack(va.exp);

    // Reset during SETTLE of bit 0.
    @(negedge clock);
    challenge = 4'h6;
    start     = 1'b1;
    puf_in    = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    for (int k = 0; k < CLR + WIN + 1; k++) begin
      @(posedge clock);
      #1;
    end
    chk("pre_reset", {ro_enable, ro_reset, busy, select1},
        {3'b001, 4'h6});
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("mid_reset",
        {select1, select2, ro_enable, ro_reset, busy,
         resp_valid, response},
        {4'h0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
